// File: rtl/pixel_event_arbiter.sv
// Per-channel strobe event detect, capture and FIFO, round-robin merged onto one valid/ready port.
// Define PIXEL_ARB_STATS_EN to build the per-channel 16-bit saturating accept/drop counters.

module pixel_event_lane #(
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int B_W        = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int EDGE_MODE  = 1,
  localparam int D_W       = X_W + Y_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [B_W-1:0] b_i,
  input  logic           valid_i,
  input  logic           pop_i,
  output logic [D_W-1:0] head_o,
  output logic           nempty_o,
  output logic           ovf_o,
  output logic [15:0]    acc_o,
  output logic [15:0]    drop_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic           s1_q, s2_q, ovf_q;
  logic [D_W-1:0] cap_q;
  logic [D_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wp_q, rp_q;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic           evt, full, push_ok, drop;

  assign evt = (EDGE_MODE == 0) ? (s1_q & ~s2_q) :
               (EDGE_MODE == 2) ? s1_q : (s2_q & ~s1_q);
  assign full    = (lvl_q == LW'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok = evt & (~full | pop_i);
  assign drop    = evt & full & ~pop_i;

  always_comb begin
    lvl_d = lvl_q;
    if (push_ok && !pop_i)      lvl_d = lvl_q + LW'(1);
    else if (!push_ok && pop_i) lvl_d = lvl_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cap_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= valid_i;
      s2_q  <= s1_q;
      if (valid_i) cap_q <= {x_i, y_i, b_i};
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop_i)   rp_q <= rp_q + AW'(1);
      lvl_q <= lvl_d;
      if (drop)    ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= cap_q;
  end

  assign head_o   = mem_q[rp_q];
  assign nempty_o = (lvl_q != '0);
  assign ovf_o    = ovf_q;

`ifdef PIXEL_ARB_STATS_EN
  logic [15:0] acc_q, drop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok && acc_q != 16'hFFFF) acc_q  <= acc_q + 16'd1;
      if (drop && drop_q != 16'hFFFF)   drop_q <= drop_q + 16'd1;
    end
  end
  assign acc_o  = acc_q;
  assign drop_o = drop_q;
`else
  assign acc_o  = '0;
  assign drop_o = '0;
`endif
endmodule

module pixel_event_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int B_W        = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int EDGE_MODE  = 1,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*X_W-1:0]  in_x,
  input  logic [NUM_CH*Y_W-1:0]  in_y,
  input  logic [NUM_CH*B_W-1:0]  in_bright,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [X_W-1:0]         out_x,
  output logic [Y_W-1:0]         out_y,
  output logic [B_W-1:0]         out_bright,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_CH-1:0]      overflow,
  output logic [NUM_CH*16-1:0]   stat_accept,
  output logic [NUM_CH*16-1:0]   stat_drop
);
  localparam int D_W = X_W + Y_W + B_W;

  logic [NUM_CH-1:0][D_W-1:0] head;
  logic [NUM_CH-1:0]          nempty, pop;
  logic [CH_W-1:0]            ptr_q, win, cand;
  logic                       found, load;
  logic [D_W-1:0]             out_q;
  logic [CH_W-1:0]            out_ch_q;
  logic                       out_valid_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    pixel_event_lane #(
      .X_W(X_W), .Y_W(Y_W), .B_W(B_W), .FIFO_DEPTH(FIFO_DEPTH), .EDGE_MODE(EDGE_MODE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .x_i      (in_x[c*X_W +: X_W]),
      .y_i      (in_y[c*Y_W +: Y_W]),
      .b_i      (in_bright[c*B_W +: B_W]),
      .valid_i  (in_valid[c]),
      .pop_i    (pop[c]),
      .head_o   (head[c]),
      .nempty_o (nempty[c]),
      .ovf_o    (overflow[c]),
      .acc_o    (stat_accept[c*16 +: 16]),
      .drop_o   (stat_drop[c*16 +: 16])
    );
    assign pop[c] = load && (win == CH_W'(c));
  end

  // Search begins one past the last grant and wraps; first non-empty FIFO wins.
  always_comb begin
    win   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found && nempty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign load = (~out_valid_q | out_ready) & found;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= CH_W'(NUM_CH - 1);
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      ptr_q       <= win;
      out_q       <= head[win];
      out_ch_q    <= win;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_x      = out_q[D_W-1 -: X_W];
  assign out_y      = out_q[B_W +: Y_W];
  assign out_bright = out_q[B_W-1:0];
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_pixel_event_arbiter.sv
// Directed bench: three 2-channel instances, one per edge mode, sharing all inputs.
module tb_pixel_event_arbiter;
  localparam int NCH = 2, XW = 10, YW = 10, BW = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH*XW-1:0]   in_x = '0;
  logic [NCH*YW-1:0]   in_y = '0;
  logic [NCH*BW-1:0]   in_bright = '0;
  logic [NCH-1:0]      in_valid = '0;
  logic                out_ready = 1'b1;

  logic [XW-1:0]       ox   [3];
  logic [YW-1:0]       oy   [3];
  logic [BW-1:0]       ob   [3];
  logic                och  [3];
  logic                ov   [3];
  logic [NCH-1:0]      ovf  [3];
  logic [NCH*16-1:0]   sacc [3];
  logic [NCH*16-1:0]   sdrp [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    pixel_event_arbiter #(
      .NUM_CH(NCH), .X_W(XW), .Y_W(YW), .B_W(BW), .FIFO_DEPTH(4), .EDGE_MODE(m)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_bright   (in_bright),
      .in_valid    (in_valid),
      .out_x       (ox[m]),
      .out_y       (oy[m]),
      .out_bright  (ob[m]),
      .out_ch      (och[m]),
      .out_valid   (ov[m]),
      .out_ready   (out_ready),
      .overflow    (ovf[m]),
      .stat_accept (sacc[m]),
      .stat_drop   (sdrp[m])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input int x, input int y, input int b);
    in_valid[c]             = v;
    in_x[c*XW +: XW]        = XW'(x);
    in_y[c*YW +: YW]        = YW'(y);
    in_bright[c*BW +: BW]   = BW'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    for (int m = 0; m < 3; m++) begin
      n_vec++;
      if (ov[m] !== 1'b0) begin n_err++; $display("FAIL rst_valid m%0d got %b want 0", m, ov[m]); end
      n_vec++;
      if (ovf[m] !== 2'b00) begin n_err++; $display("FAIL rst_ovf m%0d got %b want 00", m, ovf[m]); end
      n_vec++;
      if ({ox[m], oy[m], ob[m], och[m]} !== '0) begin
        n_err++; $display("FAIL rst_data m%0d got x=%0d y=%0d b=%0d ch=%0d want 0", m, ox[m], oy[m], ob[m], och[m]);
      end
      n_vec++;
      if (sacc[m] !== '0 || sdrp[m] !== '0) begin
        n_err++; $display("FAIL rst_stats m%0d got acc=%h drop=%h want 0", m, sacc[m], sdrp[m]);
      end
    end
    rst = 1'b0;
  endtask

  // Falling mode: low sampled at E1, push at E2, out_valid after E3.
  task automatic test_latency();
    do_reset();
    set_ch(0, 1'b1, 100, 200, 5);
    step();
    set_ch(0, 1'b0, 0, 0, 0);
    step();
    n_vec++;
    if (ov[1] !== 1'b0) begin n_err++; $display("FAIL lat_e1 valid got %b want 0", ov[1]); end
    step();
    n_vec++;
    if (ov[1] !== 1'b0) begin n_err++; $display("FAIL lat_e2 valid got %b want 0", ov[1]); end
    step();
    n_vec++;
    if (ov[1] !== 1'b1) begin n_err++; $display("FAIL lat_e3 valid got %b want 1", ov[1]); end
    n_vec++;
    if (ox[1] !== 10'd100 || oy[1] !== 10'd200 || ob[1] !== 3'd5 || och[1] !== 1'b0) begin
      n_err++; $display("FAIL lat_beat got x=%0d y=%0d b=%0d ch=%0d want 100 200 5 0", ox[1], oy[1], ob[1], och[1]);
    end
    step();
    n_vec++;
    if (ov[1] !== 1'b0) begin n_err++; $display("FAIL lat_single valid got %b want 0", ov[1]); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      int t = 0;
      set_ch(0, 1'b1, 10 + r, 1, 1);
      set_ch(1, 1'b1, 20 + r, 2, 2);
      step();
      set_ch(0, 1'b0, 0, 0, 0);
      set_ch(1, 1'b0, 0, 0, 0);
      while (ov[1] !== 1'b1 && t < 8) begin step(); t++; end
      n_vec++;
      if (ov[1] !== 1'b1 || ox[1] !== XW'(10 + r) || och[1] !== 1'b0) begin
        n_err++; $display("FAIL sim_first r%0d got v=%b x=%0d ch=%0d want 1 %0d 0", r, ov[1], ox[1], och[1], 10 + r);
      end
      step();
      n_vec++;
      if (ov[1] !== 1'b1 || ox[1] !== XW'(20 + r) || och[1] !== 1'b1) begin
        n_err++; $display("FAIL sim_second r%0d got v=%b x=%0d ch=%0d want 1 %0d 1", r, ov[1], ox[1], och[1], 20 + r);
      end
      step();
      n_vec++;
      if (ov[1] !== 1'b0) begin n_err++; $display("FAIL sim_end r%0d valid got %b want 0", r, ov[1]); end
    end
  endtask

  task automatic test_overflow_stall();
    logic [XW+YW+BW+1:0] snap;
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_ch(0, 1'b1, k, k + 50, k);
      step();
      set_ch(0, 1'b0, 0, 0, 0);
      step();
    end
    step(); step(); step();
    n_vec++;
    if (ovf[1] !== 2'b01) begin n_err++; $display("FAIL ovf_flag got %b want 01", ovf[1]); end
    n_vec++;
    if (ov[1] !== 1'b1 || ox[1] !== 10'd1) begin
      n_err++; $display("FAIL ovf_head got v=%b x=%0d want 1 1", ov[1], ox[1]);
    end
    snap = {ox[1], oy[1], ob[1], och[1], ov[1]};
    for (int t = 0; t < 10; t++) begin
      step();
      n_vec++;
      if ({ox[1], oy[1], ob[1], och[1], ov[1]} !== snap) begin
        n_err++; $display("FAIL stall_hold t%0d got %h want %h", t, {ox[1], oy[1], ob[1], och[1], ov[1]}, snap);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n_vec++;
      if (ov[1] !== 1'b1 || ox[1] !== XW'(k) || oy[1] !== YW'(k + 50) || ob[1] !== BW'(k)) begin
        n_err++; $display("FAIL drain_%0d got v=%b x=%0d y=%0d b=%0d want 1 %0d %0d %0d", k, ov[1], ox[1], oy[1], ob[1], k, k + 50, k % 8);
      end
      step();
    end
    n_vec++;
    if (ov[1] !== 1'b0) begin n_err++; $display("FAIL drain_end valid got %b want 0", ov[1]); end
`ifdef PIXEL_ARB_STATS_EN
    n_vec++;
    if (sdrp[1][15:0] !== 16'd1 || sacc[1][15:0] !== 16'd5) begin
      n_err++; $display("FAIL stat_ch0 got acc=%0d drop=%0d want 5 1", sacc[1][15:0], sdrp[1][15:0]);
    end
`else
    n_vec++;
    if (sdrp[1] !== '0 || sacc[1] !== '0) begin
      n_err++; $display("FAIL stat_tied got acc=%h drop=%h want 0", sacc[1], sdrp[1]);
    end
`endif
  endtask

  // Runs straight after the overflow test so the sticky flag is still set.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 7; k <= 9; k++) begin
      set_ch(0, 1'b1, k, 0, 0);
      step();
      set_ch(0, 1'b0, 0, 0, 0);
      step();
    end
    step(); step();
    n_vec++;
    if (ov[1] !== 1'b1 || ovf[1] !== 2'b01) begin
      n_err++; $display("FAIL mid_pre got v=%b ovf=%b want 1 01", ov[1], ovf[1]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (ov[1] !== 1'b0 || ovf[1] !== 2'b00) begin
      n_err++; $display("FAIL mid_rst got v=%b ovf=%b want 0 00", ov[1], ovf[1]);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      n_vec++;
      if (ov[1] !== 1'b0) begin n_err++; $display("FAIL mid_stale t%0d got v=%b x=%0d want 0", t, ov[1], ox[1]); end
    end
  endtask

  task automatic test_edge_modes();
    int q0[$], q1[$], q2[$];
    do_reset();
    for (int t = 0; t < 14; t++) begin
      if (t < 4) set_ch(0, 1'b1, t + 1, 0, 0);
      else       set_ch(0, 1'b0, 0, 0, 0);
      step();
      if (ov[0] === 1'b1) q0.push_back(int'(ox[0]));
      if (ov[1] === 1'b1) q1.push_back(int'(ox[1]));
      if (ov[2] === 1'b1) q2.push_back(int'(ox[2]));
    end
    n_vec++;
    if (q0.size() != 1 || q0[0] != 1) begin
      n_err++; $display("FAIL mode0 got %0d beats first=%0d want 1 beat x=1", q0.size(), (q0.size() > 0) ? q0[0] : -1);
    end
    n_vec++;
    if (q1.size() != 1 || q1[0] != 4) begin
      n_err++; $display("FAIL mode1 got %0d beats first=%0d want 1 beat x=4", q1.size(), (q1.size() > 0) ? q1[0] : -1);
    end
    n_vec++;
    if (q2.size() != 4) begin
      n_err++; $display("FAIL mode2_count got %0d want 4", q2.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (q2[k] != k + 1) begin n_err++; $display("FAIL mode2_beat%0d got %0d want %0d", k, q2[k], k + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_simultaneous();
    test_overflow_stall();
    test_reset_mid();
    test_edge_modes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
